ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Shares the single 512-word RAM between two requesters: the CPU control unit (MAR/MDR path) and the program/debug loader.
- Grants one transaction at a time.
- Sequences the RAM enable, read and write strobes, then returns read data with a one-cycle ack pulse.
- Sits between the requesters and the RAM; it replaces direct strobe wiring from the control unit.

Parameters:
ADDR_WIDTH, 9, RAM address width (matches MAR output)
DATA_WIDTH, 32, data word width
READ_LATENCY, 1, edges from the ram_read ISSUE cycle until ram_rdata is valid; legal range 1..4

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU transaction request; held high until cpu_ack
cpu_we  in  1  CPU request type: 1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_rdata  out  DATA_WIDTH  CPU read data, registered
cpu_ack  out  1  one-cycle CPU completion pulse
ldr_req  in  1  loader transaction request
ldr_we  in  1  loader request type: 1 = write, 0 = read
ldr_addr  in  ADDR_WIDTH  loader address
ldr_wdata  in  DATA_WIDTH  loader write data
ldr_lock  in  1  loader keeps ownership across back-to-back transactions
ldr_rdata  out  DATA_WIDTH  loader read data, registered
ldr_ack  out  1  one-cycle loader completion pulse
ram_enable  out  1  RAM chip enable
ram_read  out  1  RAM read strobe
ram_write  out  1  RAM write strobe
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data
busy  out  1  high in any state other than IDLE
grant_ldr  out  1  the current or last transaction belongs to the loader

Behaviour:
- Reset: synchronous and active-high.
  - State goes to IDLE.
  - All strobes, acks and busy go to 0.
  - cpu_rdata and ldr_rdata go to 0; ram_addr and ram_wdata go to 0.
  - last_grant is set to LDR, so the CPU wins the first tie.
  - Reset overrides any in-flight transaction: no ack is issued and the aborted transaction is dropped.
- States: IDLE -> ISSUE -> (WAIT, reads only) -> DONE -> IDLE.
- IDLE arbitration:
  - Only one requester high: that requester is granted.
  - Both high, with last_grant = LDR, ldr_lock = 1 and ldr_req = 1: the loader is granted (lock).
  - Both high, otherwise: the requester that is not last_grant is granted (round-robin).
  - ldr_lock has no effect unless the loader held the previous grant.
  - On grant: latch we, addr and wdata from the winner; update last_grant and grant_ldr; go to ISSUE.
  - Neither requesting: stay in IDLE with all strobes at 0.
- ISSUE (exactly one cycle):
  - ram_enable = 1.
  - ram_write = latched we; ram_read = the inverse of latched we.
  - ram_addr and ram_wdata are driven from the latched values.
  - Write: go to DONE. Read: load the latency counter with READ_LATENCY-1 and go to WAIT.
- WAIT:
  - ram_enable = 1 and ram_addr is held; ram_read = 0 and ram_write = 0.
  - Counter = 0: capture ram_rdata into the granted requester's rdata register and go to DONE.
  - Otherwise: decrement the counter.
- DONE (one cycle):
  - The granted requester's ack = 1; all strobes = 0.
  - Go to IDLE.
  - The rdata register holds its value until the next read by the same requester.
- Latency from the first IDLE cycle with req high, when uncontended:
  - Write: ack in the 3rd cycle.
  - Read: ack in the (3 + READ_LATENCY)th cycle.
- Requester rules:
  - Inputs are latched at grant; later changes to addr, wdata or we are ignored.
  - If req drops mid-transaction, the transaction still completes and ack still pulses.
  - If req is still high in the cycle after ack, it is treated as a new request.
- Only one ack may be high in any cycle; acks never occur outside DONE.

Test Plan:
1. Assert reset for 2 cycles with random inputs -> all outputs 0, busy = 0, no strobes; after release, a simultaneous cpu_req/ldr_req grants the CPU.
2. CPU write, addr 0x005, data 0xDEADBEEF -> cycle 2: ram_enable = 1, ram_write = 1, ram_addr = 0x005, ram_wdata = 0xDEADBEEF; cycle 3: cpu_ack = 1; ldr_ack stays 0.
3. CPU read, addr 0x1FF, RAM model returns 0x12345678, READ_LATENCY = 1 and = 3 -> cpu_ack in cycle 4 and cycle 6 respectively, with cpu_rdata = 0x12345678; ram_read is high for exactly one cycle.
4. Both requesters hold requests for 4 transactions with ldr_lock = 0 -> grant order CPU, LDR, CPU, LDR; grant_ldr tracks each grant.
5. Loader issues 3 back-to-back writes with ldr_lock = 1 while cpu_req is held high -> all 3 loader writes complete first; the CPU is granted in the IDLE cycle after ldr_lock drops.
6. Assert reset in the 2nd WAIT cycle of a READ_LATENCY = 3 loader read -> no ldr_ack, ldr_rdata = 0, state IDLE, strobes 0; the next cpu_req completes normally.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module      : ram_arbiter                                              |
// | Description : Two-port arbiter sharing one single-port RAM between the |
// |               CPU control unit and the program/debug loader. Grants    |
// |               one transaction at a time, sequences the RAM enable,     |
// |               read and write strobes, captures read data and returns   |
// |               a one-cycle ack to the winning requester.                |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
// | Ports                                                                  |
// |   clock, reset           : clock and synchronous active-high reset     |
// |   cpu_req/we/addr/wdata  : CPU request; cpu_rdata, cpu_ack returned    |
// |   ldr_req/we/addr/wdata  : loader request; ldr_lock keeps ownership    |
// |                            across back-to-back transactions;           |
// |                            ldr_rdata, ldr_ack returned                 |
// |   ram_enable/read/write  : RAM strobes                                 |
// |   ram_addr/wdata         : RAM address and write data (latched)        |
// |   ram_rdata              : RAM read data, READ_LATENCY edges after     |
// |                            the ISSUE cycle                             |
// |   busy                   : arbiter not in IDLE                         |
// |   grant_ldr              : current or last transaction is the loader's |
// +------------------------------------------------------------------------+
// READ_LATENCY must lie in 1..4.
module ram_arbiter #(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    input  logic                  ldr_lock,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  ldr_ack,
    output logic                  ram_enable,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  grant_ldr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter holds READ_LATENCY-1 at most (3), so two bits suffice.
    localparam logic [1:0] C_CNT_LOAD = 2'(READ_LATENCY - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_last_ldr;    // last_grant: 1 = loader
    logic                    r_grant_ldr;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_cpu_rdata;
    logic [DATA_WIDTH-1:0]   r_ldr_rdata;
    logic [1:0]              r_cnt;

    logic                    w_grant;
    logic                    w_pick_ldr;
    logic                    w_capture;

    // Loader wins when it is the only requester, when the CPU had the last
    // grant (round-robin), or when it held the last grant and asserts lock.
    assign w_pick_ldr = ldr_req && (!cpu_req || !r_last_ldr || ldr_lock);
    assign w_grant    = (r_state == ST_IDLE) && (cpu_req || ldr_req);
    assign w_capture  = (r_state == ST_WAIT) && (r_cnt == 2'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_last_ldr  <= 1'b1;
            r_grant_ldr <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_ldr_rdata <= '0;
            r_cnt       <= 2'd0;
        end else begin
            r_state <= w_next_state;

            if (w_grant) begin
                r_we        <= w_pick_ldr ? ldr_we    : cpu_we;
                r_addr      <= w_pick_ldr ? ldr_addr  : cpu_addr;
                r_wdata     <= w_pick_ldr ? ldr_wdata : cpu_wdata;
                r_last_ldr  <= w_pick_ldr;
                r_grant_ldr <= w_pick_ldr;
            end

            if ((r_state == ST_ISSUE) && !r_we) begin
                r_cnt <= C_CNT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end

            if (w_capture) begin
                if (r_grant_ldr) begin
                    r_ldr_rdata <= ram_rdata;
                end else begin
                    r_cpu_rdata <= ram_rdata;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        ram_enable   = 1'b0;
        ram_read     = 1'b0;
        ram_write    = 1'b0;
        cpu_ack      = 1'b0;
        ldr_ack      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cpu_req || ldr_req) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ram_enable   = 1'b1;
                ram_write    = r_we;
                ram_read     = !r_we;
                w_next_state = r_we ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                // Enable and address stay asserted while the RAM pipeline drains.
                ram_enable = 1'b1;
                if (r_cnt == 2'd0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                cpu_ack      = !r_grant_ldr;
                ldr_ack      = r_grant_ldr;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign busy      = (r_state != ST_IDLE);
    assign grant_ldr = r_grant_ldr;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign cpu_rdata = r_cpu_rdata;
    assign ldr_rdata = r_ldr_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module      : tb_ram_arbiter                                           |
// | Description : Directed self-checking bench. Two arbiters (latency 1    |
// |               and latency 3) share the same requester inputs, each    |
// |               with its own RAM read pipeline over a common memory.     |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
    logic [8:0]  cpu_addr, ldr_addr;
    logic [31:0] cpu_wdata, ldr_wdata;

    // suffix _a: READ_LATENCY = 1, suffix _b: READ_LATENCY = 3
    logic [31:0] cpu_rdata_a, ldr_rdata_a, ram_wdata_a, rd_a;
    logic [31:0] cpu_rdata_b, ldr_rdata_b, ram_wdata_b, rd_b;
    logic        cpu_ack_a, ldr_ack_a, ram_enable_a, ram_read_a, ram_write_a, busy_a, grant_ldr_a;
    logic        cpu_ack_b, ldr_ack_b, ram_enable_b, ram_read_b, ram_write_b, busy_b, grant_ldr_b;
    logic [8:0]  ram_addr_a, ram_addr_b;
    logic [31:0] p0_b, p1_b;
    logic [31:0] mem [0:511];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(1)) dut_a (
        .clock(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_a), .cpu_ack(cpu_ack_a),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_rdata(ldr_rdata_a), .ldr_ack(ldr_ack_a),
        .ram_enable(ram_enable_a), .ram_read(ram_read_a), .ram_write(ram_write_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_rdata(rd_a),
        .busy(busy_a), .grant_ldr(grant_ldr_a)
    );

    ram_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .READ_LATENCY(3)) dut_b (
        .clock(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_rdata(ldr_rdata_b), .ldr_ack(ldr_ack_b),
        .ram_enable(ram_enable_b), .ram_read(ram_read_b), .ram_write(ram_write_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(rd_b),
        .busy(busy_b), .grant_ldr(grant_ldr_b)
    );

    // RAM models: writes come from dut_b (both arbiters write identically);
    // read data is valid only in the cycle READ_LATENCY edges after the
    // read strobe, zero otherwise, so capture timing errors show up.
    always @(posedge clk) begin
        if (ram_enable_b && ram_write_b) mem[ram_addr_b] <= ram_wdata_b;
        rd_a <= ram_read_a ? mem[ram_addr_a] : 32'h0;
        p0_b <= ram_read_b ? mem[ram_addr_b] : 32'h0;
        p1_b <= p0_b;
        rd_b <= p1_b;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
    endtask

    task automatic rand_inputs;
        cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 9'($urandom); cpu_wdata = $urandom;
        ldr_req = 1'($urandom); ldr_we = 1'($urandom); ldr_addr = 9'($urandom); ldr_wdata = $urandom;
        ldr_lock = 1'($urandom);
    endtask

    // Uncontended write from one requester, starting in IDLE; req is held
    // only for the grant cycle and request fields are scrambled afterwards.
    task automatic single_write(input string tag, input bit ldr, input logic [8:0] a,
                                input logic [31:0] d);
        if (ldr) begin ldr_req = 1; ldr_we = 1; ldr_addr = a; ldr_wdata = d; end
        else     begin cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d; end
        tick;
        chk({tag, "_strobes"}, {29'd0, ram_enable_b, ram_write_b, ram_read_b}, 32'd6);
        chk({tag, "_addr"}, {23'd0, ram_addr_b}, {23'd0, a});
        chk({tag, "_wdata"}, ram_wdata_b, d);
        chk({tag, "_grant"}, {31'd0, grant_ldr_b}, {31'd0, ldr});
        clear_inputs();
        cpu_addr = 9'h1AB; ldr_addr = 9'h1CD; cpu_wdata = 32'hFFFF0000; ldr_wdata = 32'h0000FFFF;
        tick;
        chk({tag, "_acks"}, {30'd0, cpu_ack_b, ldr_ack_b}, {30'd0, !ldr, ldr});
        chk({tag, "_done_en"}, {31'd0, ram_enable_b}, 32'd0);
        clear_inputs();
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. reset with random inputs
        reset = 1;
        rand_inputs(); tick;
        rand_inputs(); tick;
        chk("rst_busy", {30'd0, busy_a, busy_b}, 32'd0);
        chk("rst_strobes", {26'd0, ram_enable_a, ram_read_a, ram_write_a,
                            ram_enable_b, ram_read_b, ram_write_b}, 32'd0);
        chk("rst_acks", {28'd0, cpu_ack_a, ldr_ack_a, cpu_ack_b, ldr_ack_b}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata_b, 32'd0);
        chk("rst_ldr_rdata", ldr_rdata_b, 32'd0);
        chk("rst_ram_addr", {23'd0, ram_addr_b}, 32'd0);
        chk("rst_ram_wdata", ram_wdata_b, 32'd0);
        chk("rst_grant_ldr", {31'd0, grant_ldr_b}, 32'd0);

        // first tie after reset goes to the CPU
        reset = 0; clear_inputs();
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h0AA; cpu_wdata = 32'h11110000;
        ldr_req = 1; ldr_we = 1; ldr_addr = 9'h0BB; ldr_wdata = 32'h22220000;
        tick;
        chk("tie_grant", {31'd0, grant_ldr_b}, 32'd0);
        chk("tie_addr", {23'd0, ram_addr_b}, 32'h0AA);
        clear_inputs();
        tick;
        chk("tie_acks", {30'd0, cpu_ack_b, ldr_ack_b}, 32'd2);
        tick;

        // 2. CPU write; then a loader-only write to seed 0x1FF
        single_write("cpu_wr", 1'b0, 9'h005, 32'hDEADBEEF);
        single_write("ldr_wr", 1'b1, 9'h1FF, 32'h12345678);

        // 3. CPU read of 0x1FF on both latencies
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h1FF;
        tick;                                   // cycle 2: ISSUE
        chk("rd_issue", {26'd0, ram_enable_a, ram_read_a, ram_write_a,
                         ram_enable_b, ram_read_b, ram_write_b}, 32'h36);
        clear_inputs();
        tick;                                   // cycle 3: WAIT
        chk("rd_wait", {28'd0, ram_enable_a, ram_read_a, ram_enable_b, ram_read_b}, 32'hA);
        chk("rd_wait_ack", {30'd0, cpu_ack_a, cpu_ack_b}, 32'd0);
        tick;                                   // cycle 4
        chk("rd_l1_ack", {30'd0, cpu_ack_a, cpu_ack_b}, 32'd2);
        chk("rd_l1_data", cpu_rdata_a, 32'h12345678);
        tick;                                   // cycle 5
        chk("rd_l3_c5", {29'd0, cpu_ack_a, cpu_ack_b, busy_b}, 32'd1);
        tick;                                   // cycle 6
        chk("rd_l3_ack", {30'd0, cpu_ack_b, ldr_ack_b}, 32'd2);
        chk("rd_l3_data", cpu_rdata_b, 32'h12345678);
        tick;

        // 4. round-robin; loader write first so last_grant = LDR
        single_write("rr_pre", 1'b1, 9'h0C0, 32'hC0C0C0C0);
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 32'h01010101;
        ldr_req = 1; ldr_we = 1; ldr_addr = 9'h020; ldr_wdata = 32'h02020202;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("rr%0d_grant", k), {31'd0, grant_ldr_b}, 32'(k % 2));
            chk($sformatf("rr%0d_addr", k), {23'd0, ram_addr_b}, (k % 2) ? 32'h020 : 32'h010);
            tick;
            chk($sformatf("rr%0d_acks", k), {30'd0, cpu_ack_b, ldr_ack_b}, (k % 2) ? 32'd1 : 32'd2);
            if (k == 3) clear_inputs();
            tick;
        end

        // 5. loader lock holds off a waiting CPU for 3 writes
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h030; cpu_wdata = 32'h30303030;
        ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 9'h100; ldr_wdata = 32'hA0000000;
        for (int j = 0; j < 3; j++) begin
            tick;
            chk($sformatf("lk%0d_grant", j), {31'd0, grant_ldr_b}, 32'd1);
            chk($sformatf("lk%0d_addr", j), {23'd0, ram_addr_b}, 32'h100 + 32'(j));
            tick;
            chk($sformatf("lk%0d_acks", j), {30'd0, cpu_ack_b, ldr_ack_b}, 32'd1);
            ldr_addr = 9'h101 + 9'(j); ldr_wdata = 32'hA0000001 + 32'(j);
            if (j == 2) begin ldr_req = 0; ldr_lock = 0; end
            tick;
        end
        tick;
        chk("lk_cpu_grant", {31'd0, grant_ldr_b}, 32'd0);
        chk("lk_cpu_addr", {23'd0, ram_addr_b}, 32'h030);
        clear_inputs();
        tick;
        chk("lk_cpu_ack", {30'd0, cpu_ack_b, ldr_ack_b}, 32'd2);
        chk("lk_mem", mem[9'h102], 32'hA0000002);
        tick;

        // 6. loader read completes, then a second read is killed by reset
        ldr_req = 1; ldr_we = 0; ldr_addr = 9'h005;
        tick;
        chk("lr_issue", {31'd0, ram_read_b}, 32'd1);
        clear_inputs();
        tick; tick; tick;
        chk("lr_w3_ack", {31'd0, ldr_ack_b}, 32'd0);
        tick;
        chk("lr_ack", {30'd0, cpu_ack_b, ldr_ack_b}, 32'd1);
        chk("lr_data", ldr_rdata_b, 32'hDEADBEEF);
        tick;
        ldr_req = 1; ldr_we = 0; ldr_addr = 9'h1FF;
        tick;                                   // ISSUE
        clear_inputs();
        tick;                                   // WAIT 1
        tick;                                   // WAIT 2
        chk("ab_busy", {31'd0, busy_b}, 32'd1);
        reset = 1;
        tick;
        chk("ab_state", {28'd0, busy_b, ram_enable_b, ram_read_b, ram_write_b}, 32'd0);
        chk("ab_ack", {30'd0, cpu_ack_b, ldr_ack_b}, 32'd0);
        chk("ab_rdata", ldr_rdata_b, 32'd0);
        reset = 0;
        tick; tick; tick;
        chk("ab_quiet", {29'd0, busy_b, cpu_ack_b, ldr_ack_b}, 32'd0);
        single_write("post_rst", 1'b0, 9'h040, 32'h40404040);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
